// File: rtl/fp_mult.sv
// Two-stage IEEE-754 binary32 multiplier with six rounding modes and exception flags.
// Optional FP_MULT_NAN_PROP_EN: propagate input NaN payloads (quieted) instead of canonical NaN.
module fp_mult (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  rnd,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] z,
   output logic [7:0]  status
);
   localparam logic [31:0] QNAN = 32'h7FC00000;

   logic [31:0] a_q, a_d, b_q, b_d;
   logic [2:0]  rnd_q, rnd_d;
   logic        vld_q, vld_d;
   logic [31:0] z_q, z_d;
   logic [7:0]  status_q, status_d;

   logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb, frac_out;
   logic [47:0] prod;
   logic [9:0]  exp_raw, exp_norm, exp_rnd;
   logic [23:0] mant;
   logic [24:0] mant_sum;
   logic        guard, sticky, inc, overflow, underflow;
   logic [2:0]  mode;
   logic [31:0] nan_val;

   always_comb begin
      a_d   = a;
      b_d   = b;
      rnd_d = rnd;
      vld_d = 1'b1;
   end

   always_comb begin
      sign   = a_q[31] ^ b_q[31];
      ea     = a_q[30:23];
      eb     = b_q[30:23];
      fa     = a_q[22:0];
      fb     = b_q[22:0];
      // subnormal operands count as zero
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);
      mode   = (rnd_q[2:1] == 2'b11) ? 3'b000 : rnd_q;

      prod    = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
      exp_raw = {2'b00, ea} + {2'b00, eb} - 10'd127;
      if (prod[47]) begin
         mant     = prod[47:24];
         guard    = prod[23];
         sticky   = |prod[22:0];
         exp_norm = exp_raw + 10'd1;
      end else begin
         mant     = prod[46:23];
         guard    = prod[22];
         sticky   = |prod[21:0];
         exp_norm = exp_raw;
      end

      case (mode)
         3'b001:  inc = 1'b0;
         3'b010:  inc = ~sign & (guard | sticky);
         3'b011:  inc = sign & (guard | sticky);
         3'b100:  inc = guard & (sticky | ~sign);
         3'b101:  inc = guard | sticky;
         default: inc = guard & (sticky | mant[0]);
      endcase

      mant_sum = {1'b0, mant} + {24'd0, inc};
      if (mant_sum[24]) begin
         frac_out = mant_sum[23:1];
         exp_rnd  = exp_norm + 10'd1;
      end else begin
         frac_out = mant_sum[22:0];
         exp_rnd  = exp_norm;
      end
      overflow  = $signed(exp_rnd) >= $signed(10'sd255);
      underflow = $signed(exp_rnd) <= $signed(10'sd0);

`ifdef FP_MULT_NAN_PROP_EN
      if (a_nan)      nan_val = a_q | 32'h0040_0000;
      else if (b_nan) nan_val = b_q | 32'h0040_0000;
      else            nan_val = QNAN;
`else
      nan_val = QNAN;
`endif
   end

   always_comb begin
      z_d      = 32'd0;
      status_d = 8'd0;
      if (vld_q) begin
         if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
            z_d         = nan_val;
            status_d[2] = 1'b1;
         end else if (a_inf || b_inf) begin
            z_d = {sign, 8'hFF, 23'd0};
         end else if (a_zero || b_zero) begin
            z_d = {sign, 31'd0};
         end else if (overflow) begin
            status_d[5:4] = 2'b11;
            case (mode)
               3'b001:  z_d = {sign, 31'h7F7FFFFF};
               3'b010:  z_d = sign ? 32'hFF7FFFFF : 32'h7F800000;
               3'b011:  z_d = sign ? 32'hFF800000 : 32'h7F7FFFFF;
               default: z_d = {sign, 31'h7F800000};
            endcase
         end else if (underflow) begin
            status_d[5] = 1'b1;
            status_d[3] = 1'b1;
            case (mode)
               3'b101:  z_d = {sign, 31'h00800000};
               3'b010:  z_d = sign ? 32'h80000000 : 32'h00800000;
               3'b011:  z_d = sign ? 32'h80800000 : 32'h00000000;
               default: z_d = {sign, 31'd0};
            endcase
         end else begin
            z_d         = {sign, exp_rnd[7:0], frac_out};
            status_d[5] = guard | sticky;
         end
         // zero/inf flags follow the delivered word, whichever path produced it
         status_d[0] = (z_d[30:0] == 31'd0);
         status_d[1] = (z_d[30:0] == 31'h7F800000);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         rnd_q    <= 3'd0;
         vld_q    <= 1'b0;
         z_q      <= 32'd0;
         status_q <= 8'd0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         rnd_q    <= rnd_d;
         vld_q    <= vld_d;
         z_q      <= z_d;
         status_q <= status_d;
      end
   end

   assign z      = z_q;
   assign status = status_q;
endmodule

// File: tb/tb_fp_mult.sv
// Directed-vector bench for fp_mult: isolated vectors, back-to-back stream, mid-stream reset.
module tb_fp_mult;
   logic        clk;
   logic        rst;
   logic [2:0]  rnd;
   logic [31:0] a, b, z;
   logic [7:0]  status;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  rnd;
      logic [31:0] z;
      logic [7:0]  st;
   } vec_t;

   localparam int N = 40;
   vec_t vecs[N];

`ifdef FP_MULT_NAN_PROP_EN
   localparam logic [31:0] NAN_A = 32'h7FC00001;
   localparam logic [31:0] NAN_B = 32'hFFC12345;
`else
   localparam logic [31:0] NAN_A = 32'h7FC00000;
   localparam logic [31:0] NAN_B = 32'h7FC00000;
`endif

   fp_mult dut (
      .clk(clk), .rst(rst), .rnd(rnd), .a(a), .b(b), .z(z), .status(status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      a   = v.a;
      b   = v.b;
      rnd = v.rnd;
   endtask

   task automatic chk_vec(input string nm, input int idx);
      chk({nm, "_z"}, idx, z, vecs[idx].z);
      chk({nm, "_st"}, idx, {24'd0, status}, {24'd0, vecs[idx].st});
   endtask

   initial begin
      vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00};
      vecs[1]  = '{32'h3F800003, 32'h3F800003, 3'd0, 32'h3F800006, 8'h20};
      vecs[2]  = '{32'h3F800003, 32'h3F800003, 3'd2, 32'h3F800007, 8'h20};
      vecs[3]  = '{32'h3F800003, 32'h3F800003, 3'd1, 32'h3F800006, 8'h20};
      vecs[4]  = '{32'h3F800003, 32'h3F800003, 3'd3, 32'h3F800006, 8'h20};
      vecs[5]  = '{32'h3F800003, 32'h3F800003, 3'd4, 32'h3F800006, 8'h20};
      vecs[6]  = '{32'h3F800003, 32'h3F800003, 3'd5, 32'h3F800007, 8'h20};
      vecs[7]  = '{32'hBF800003, 32'h3F800003, 3'd2, 32'hBF800006, 8'h20};
      vecs[8]  = '{32'hBF800003, 32'h3F800003, 3'd3, 32'hBF800007, 8'h20};
      // exact ties: mantissa lsb 0, guard 1, sticky 0
      vecs[9]  = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 8'h20};
      vecs[10] = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 8'h20};
      vecs[11] = '{32'h3F800003, 32'h3FC00000, 3'd6, 32'h3FC00004, 8'h20};
      vecs[12] = '{32'hBF800003, 32'h3FC00000, 3'd4, 32'hBFC00004, 8'h20};
      vecs[13] = '{32'hBF800003, 32'h3FC00000, 3'd5, 32'hBFC00005, 8'h20};
      // rounding carry-out of the mantissa
      vecs[14] = '{32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 8'h20};
      vecs[15] = '{32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 8'h20};
      vecs[16] = '{32'h7E800001, 32'h407FFFFE, 3'd0, 32'h7F800000, 8'h32};
      vecs[17] = '{32'h7E800001, 32'h407FFFFE, 3'd1, 32'h7F7FFFFF, 8'h20};
      vecs[18] = '{32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 8'h32};
      vecs[19] = '{32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 8'h30};
      vecs[20] = '{32'h7F000000, 32'h7F000000, 3'd3, 32'h7F7FFFFF, 8'h30};
      vecs[21] = '{32'hFF000000, 32'h7F000000, 3'd2, 32'hFF7FFFFF, 8'h30};
      vecs[22] = '{32'hFF000000, 32'h7F000000, 3'd3, 32'hFF800000, 8'h32};
      vecs[23] = '{32'hFF000000, 32'h7F000000, 3'd7, 32'hFF800000, 8'h32};
      vecs[24] = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 8'h29};
      vecs[25] = '{32'h00800000, 32'h3F000000, 3'd2, 32'h00800000, 8'h28};
      vecs[26] = '{32'h00800000, 32'h3F000000, 3'd5, 32'h00800000, 8'h28};
      vecs[27] = '{32'h80800000, 32'h3F000000, 3'd3, 32'h80800000, 8'h28};
      vecs[28] = '{32'h80800000, 32'h3F000000, 3'd2, 32'h80000000, 8'h29};
      vecs[29] = '{32'h80800000, 32'h3F000000, 3'd4, 32'h80000000, 8'h29};
      vecs[30] = '{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 8'h00};
      vecs[31] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04};
      vecs[32] = '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 8'h01};
      vecs[33] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02};
      vecs[34] = '{32'h7F800001, 32'h3F800000, 3'd0, NAN_A,        8'h04};
      vecs[35] = '{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 8'h01};
      vecs[36] = '{32'h7F800000, 32'h7F800000, 3'd1, 32'h7F800000, 8'h02};
      vecs[37] = '{32'hC0000000, 32'hC0400000, 3'd0, 32'h40C00000, 8'h00};
      vecs[38] = '{32'h3F800000, 32'hFFC12345, 3'd3, NAN_B,        8'h04};
      vecs[39] = '{32'h00000000, 32'h7F800001, 3'd0, NAN_A,        8'h04};

      // reset state, then first result two edges after release
      rst = 1'b0;
      drive(vecs[0]);
      @(posedge clk); #1;
      chk("rst_z", 0, z, 32'd0);
      chk("rst_st", 0, {24'd0, status}, 32'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk("fill_z", 0, z, 32'd0);
      chk("fill_st", 0, {24'd0, status}, 32'd0);
      @(posedge clk); #1;
      chk_vec("first", 0);

      // each vector held and checked in isolation
      for (int i = 0; i < N; i++) begin
         @(negedge clk) drive(vecs[i]);
         @(posedge clk);
         @(posedge clk); #1;
         chk_vec("iso", i);
      end

      // back-to-back: result of vector i-1 must be present right after edge i
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i < N) drive(vecs[i]);
         @(posedge clk); #1;
         if (i >= 1) chk_vec("stream", i - 1);
      end

      // reset pulse mid-stream drops in-flight results
      @(negedge clk) drive(vecs[18]);
      @(posedge clk);
      @(negedge clk) drive(vecs[21]);
      @(posedge clk); #1;
      chk_vec("pre_rst", 18);
      @(negedge clk) begin rst = 1'b0; drive(vecs[37]); end
      @(posedge clk); #1;
      chk("mid_rst_z", 0, z, 32'd0);
      chk("mid_rst_st", 0, {24'd0, status}, 32'd0);
      @(negedge clk) begin rst = 1'b1; drive(vecs[14]); end
      @(posedge clk); #1;
      chk("post_rst_z", 0, z, 32'd0);
      chk("post_rst_st", 0, {24'd0, status}, 32'd0);
      @(posedge clk); #1;
      chk_vec("post_rst", 14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_mult.md
Name:
fp_mult

Overview:
- IEEE-754 single-precision (binary32) floating-point multiplier with six selectable rounding modes and an 8-bit exception status.
- Registered inputs and registered outputs, giving a fixed two-cycle pipeline.
- Sits in the FP datapath as a standalone arithmetic unit, driven directly by the operand and rounding-mode buses.

Parameters:
- none (format fixed to binary32: 1 sign, 8 exponent, 23 fraction bits, bias 127)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- rnd  input  3  rounding mode select
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- z  output  32  product, binary32
- status  output  8  exception flags

Behaviour:
- One clock; reset is synchronous and active-low.
- rst low at a rising edge clears all pipeline registers; z=0x00000000 and status=0x00 on the following cycle.
- Stage 1: a, b, rnd are registered at edge k.
- Stage 2: the combinational multiply/round result is registered into z and status at edge k+1. Latency is 2 edges, throughput is 1 per cycle, and there is no handshake.
- Reset asserted mid-operation discards all in-flight results.
- Rounding modes (rnd):
  - 000 IEEE_near: nearest, ties to even.
  - 001 IEEE_zero: toward zero.
  - 010 IEEE_pinf: toward +inf.
  - 011 IEEE_ninf: toward -inf.
  - 100 near_up: nearest, ties toward +inf.
  - 101 away_zero: away from zero.
  - 110/111: treated as 000.
- Datapath:
  - Sign = sa XOR sb.
  - Exponent = ea + eb - 127, computed with 10-bit signed width.
  - Mantissa = {1,fa} × {1,fb}, a 48-bit product.
  - If P[47]=1, shift right by 1 and add 1 to the exponent.
  - Keep 24 bits, plus a guard bit and a sticky bit (OR of all remaining bits).
  - Round per mode. If rounding carries out (mantissa = 2^24), shift right and increment the exponent.
- Subnormal inputs (exp=0) are treated as zero; subnormal results are flushed (see underflow below).
- Special operands, with priority top-down:
  - Any NaN, or 0×inf → z=0x7FC00000, nan=1.
  - inf × nonzero → signed inf, inf=1.
  - zero × finite → signed zero, zero=1.
- Overflow (rounded exp ≥ 255): huge=1, inexact=1.
  - Modes 000/100/101 → signed inf, inf=1.
  - Mode 001 → signed max normal (0x7F7FFFFF | sign).
  - Mode 010 → +inf if positive, else -max normal.
  - Mode 011 → mirror of 010 (-inf if negative, else +max normal).
- Underflow (rounded exp ≤ 0): tiny=1, inexact=1.
  - Modes 000/001/100 → signed zero, zero=1.
  - Mode 101 → signed min normal (0x00800000 | sign).
  - Mode 010 → +min normal if positive, else -0.
  - Mode 011 → mirror of 010.
- status bit map:
  - [0] zero: z is ±0.
  - [1] inf: z is ±inf.
  - [2] nan.
  - [3] tiny.
  - [4] huge.
  - [5] inexact: guard|sticky nonzero, or overflow/underflow.
  - [7:6] always 0.

Optional Feature:
- Macro FP_MULT_NAN_PROP_EN.
- Defined: a NaN input is propagated with its payload forced quiet (bit 22 set). If both inputs are NaN, a's payload wins. 0×inf still yields 0x7FC00000.
- Undefined: every NaN result is the canonical 0x7FC00000.
- Flags are identical in both builds.

Test Plan:
- rst=0 for one edge, then rst=1 with a=0x3FC00000, b=0x40000000, rnd=000 → two edges later z=0x40400000, status=0x00. During reset, z=0 and status=0.
- a=b=0x3F800003: rnd=000 → z=0x3F800006, status=0x20; rnd=010 → z=0x3F800007, status=0x20; rnd=001 → z=0x3F800006, status=0x20.
- a=b=0x7F000000: rnd=000 → z=0x7F800000, status=0x32; rnd=001 → z=0x7F7FFFFF, status=0x30; rnd=011 → z=0x7F7FFFFF, status=0x30.
- a=0x00800000, b=0x3F000000: rnd=000 → z=0x00000000, status=0x29; rnd=010 → z=0x00800000, status=0x28.
- Specials:
  - a=0x7F800000, b=0x00000000 → z=0x7FC00000, status=0x04.
  - a=0x80000000, b=0x3F800000 → z=0x80000000, status=0x01.
  - a=0xFF800000, b=0x40000000 → z=0xFF800000, status=0x02.
- Back-to-back operands on consecutive cycles across all six rnd codes, checked against a reference model → each result appears exactly 2 edges after its inputs. A reset pulse mid-stream zeroes z/status and drops in-flight results.
